abus_master_if: RTL and testbench

- Master-side bridge that sits directly upstream of the abus arbiter and drives one master slot of its request bus.
- Accepts transactions from a local client over a valid/ready command port and buffers them in a command FIFO.
- Presents each transaction on the abus until this master is granted and acknowledged, then returns read data and status on a valid/ready response port.
- Optional timeout aborts transactions the bus never completes.

---
 rtl/abus_master_if_pkg.sv | 18 +
 rtl/abus_fifo.sv | 45 ++++
 rtl/abus_master_if.sv | 167 ++++++++++++++++
 tb/tb_abus_master_if.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abus_master_if_pkg.sv
// Shared abus definitions for the master-side bridge and the blocks that
// reuse its FIFO.
//   abus_sw()  : strb/keep field width for a given data width
//   IDLE/REQ/ABORT : master FSM state encodings
//   MID_W      : width of the master id driven on abus_mid
package abus_master_if_pkg;

  localparam int MID_W = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;

  function automatic int abus_sw(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/abus_fifo.sv
// Generic synchronous FIFO used for command/transaction buffering.
// Ports:
//   clk, rstb     : clock, asynchronous active-low reset (empties the FIFO)
//   push, din     : write one entry when not full
//   pop, dout     : dout shows the head; pop discards it when not empty
//   full, empty   : status, derived from pointers with one extra wrap bit
module abus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/abus_master_if.sv
// abus master-side bridge. Buffers client commands in a FIFO, presents each
// on the abus master slot until granted+acked (or aborted on timeout), and
// returns data/status through a one-entry response register.
// Ports:
//   abus_clk, abus_rstb      : clock, asynchronous active-low reset
//   cmd_*                    : valid/ready command port from the local client
//   rsp_*                    : valid/ready response port to the local client
//   abus_m* (out), abus_mid  : registered request to the arbiter
//   abus_mgrant/mack/mrdata  : grant for this master, shared ack and read data
module abus_master_if
  import abus_master_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MID        = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 0,
  localparam int SW        = abus_sw(DATA_WIDTH)
) (
  input  logic                  abus_clk,
  input  logic                  abus_rstb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [SW-1:0]         cmd_strb,
  input  logic [SW-1:0]         cmd_keep,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [MID_W-1:0]      abus_mid,
  output logic                  abus_mreq,
  output logic                  abus_mwrite,
  output logic                  abus_mread,
  output logic                  abus_mabort,
  output logic [SW-1:0]         abus_mstrb,
  output logic [SW-1:0]         abus_mkeep,
  output logic [DATA_WIDTH-1:0] abus_mwdata,
  output logic [ADDR_WIDTH-1:0] abus_maddress,
  input  logic                  abus_mgrant,
  input  logic                  abus_mack,
  input  logic [DATA_WIDTH-1:0] abus_mrdata
);

  localparam int CMD_W = 1 + 2 * SW + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CMD_W-1:0]      push_data;
  logic [CMD_W-1:0]      head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  done;
  logic                  h_write;
  logic [SW-1:0]         h_strb;
  logic [SW-1:0]         h_keep;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;

  assign abus_mid  = MID_W'(MID);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign push_data = {cmd_write, cmd_strb, cmd_keep, cmd_addr, cmd_wdata};
  assign {h_write, h_strb, h_keep, h_addr, h_wdata} = head;

  // A shared ack only completes our transfer when it coincides with our grant.
  assign done = abus_mreq && abus_mgrant && abus_mack;
  assign pop  = ((state == REQ) && done) || ((state == ABORT) && abus_mgrant);

  abus_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (abus_clk),
    .rstb (abus_rstb),
    .push (push),
    .pop  (pop),
    .din  (push_data),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state         <= IDLE;
      cnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_write     <= 1'b0;
      rsp_err       <= 1'b0;
      abus_mreq     <= 1'b0;
      abus_mwrite   <= 1'b0;
      abus_mread    <= 1'b0;
      abus_mabort   <= 1'b0;
      abus_mstrb    <= '0;
      abus_mkeep    <= '0;
      abus_mwdata   <= '0;
      abus_maddress <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Only issue when the response slot will be free, so it is never overwritten.
          if (!empty && (!rsp_valid || rsp_ready)) begin
            abus_mreq     <= 1'b1;
            abus_mwrite   <= h_write;
            abus_mread    <= !h_write;
            abus_mstrb    <= h_strb;
            abus_mkeep    <= h_keep;
            abus_mwdata   <= h_wdata;
            abus_maddress <= h_addr;
            cnt           <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (done) begin
            rsp_valid     <= 1'b1;
            rsp_rdata     <= abus_mwrite ? '0 : abus_mrdata;
            rsp_write     <= abus_mwrite;
            rsp_err       <= 1'b0;
            abus_mreq     <= 1'b0;
            abus_mwrite   <= 1'b0;
            abus_mread    <= 1'b0;
            abus_mstrb    <= '0;
            abus_mkeep    <= '0;
            abus_mwdata   <= '0;
            abus_maddress <= '0;
            state         <= IDLE;
          end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
            abus_mabort <= 1'b1;
            state       <= ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          if (abus_mgrant) begin
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_write     <= abus_mwrite;
            rsp_err       <= 1'b1;
            abus_mreq     <= 1'b0;
            abus_mwrite   <= 1'b0;
            abus_mread    <= 1'b0;
            abus_mabort   <= 1'b0;
            abus_mstrb    <= '0;
            abus_mkeep    <= '0;
            abus_mwdata   <= '0;
            abus_maddress <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abus_master_if.sv
// Directed testbench for abus_master_if (ADDR/DATA 16, MID 5, FIFO_DEPTH 4,
// TIMEOUT 8). Inputs change on the falling edge; outputs are checked there.
module tb_abus_master_if;

  localparam int SW = 5;

  logic        abus_clk = 1'b0;
  logic        abus_rstb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [SW-1:0] cmd_keep = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_err;
  logic [2:0]  abus_mid;
  logic        abus_mreq;
  logic        abus_mwrite;
  logic        abus_mread;
  logic        abus_mabort;
  logic [SW-1:0] abus_mstrb;
  logic [SW-1:0] abus_mkeep;
  logic [15:0] abus_mwdata;
  logic [15:0] abus_maddress;
  logic        abus_mgrant = 1'b0;
  logic        abus_mack = 1'b0;
  logic [15:0] abus_mrdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 abus_clk = ~abus_clk;

  abus_master_if #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .MID(5),
    .FIFO_DEPTH(4),
    .TIMEOUT(8)
  ) dut (
    .abus_clk     (abus_clk),
    .abus_rstb    (abus_rstb),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_strb     (cmd_strb),
    .cmd_keep     (cmd_keep),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_write    (rsp_write),
    .rsp_err      (rsp_err),
    .abus_mid     (abus_mid),
    .abus_mreq    (abus_mreq),
    .abus_mwrite  (abus_mwrite),
    .abus_mread   (abus_mread),
    .abus_mabort  (abus_mabort),
    .abus_mstrb   (abus_mstrb),
    .abus_mkeep   (abus_mkeep),
    .abus_mwdata  (abus_mwdata),
    .abus_maddress(abus_maddress),
    .abus_mgrant  (abus_mgrant),
    .abus_mack    (abus_mack),
    .abus_mrdata  (abus_mrdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge abus_clk);
    @(negedge abus_clk);
  endtask

  task automatic set_cmd(input logic w, input logic [15:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = 5'h1f;
    cmd_keep  = 5'h03;
  endtask

  task automatic bus(input logic g, input logic k, input logic [15:0] rd);
    abus_mgrant = g;
    abus_mack   = k;
    abus_mrdata = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid", 32'(abus_mid), 32'd5);
    check("rst_mreq", 32'(abus_mreq), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    abus_rstb = 1'b1;
    tick();

    // Single read
    set_cmd(1'b0, 16'h0040, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    check("rd_mreq_not_yet", 32'(abus_mreq), 32'd0);
    tick();
    check("rd_mreq", 32'(abus_mreq), 32'd1);
    check("rd_mread", 32'(abus_mread), 32'd1);
    check("rd_mwrite", 32'(abus_mwrite), 32'd0);
    check("rd_addr", 32'(abus_maddress), 32'h0040);
    check("rd_strb", 32'(abus_mstrb), 32'h1f);
    check("rd_keep", 32'(abus_mkeep), 32'h03);
    tick();
    tick();
    check("rd_addr_held", 32'(abus_maddress), 32'h0040);
    check("rd_no_rsp_early", 32'(rsp_valid), 32'd0);
    bus(1'b1, 1'b1, 16'hBEEF);
    tick();
    bus(1'b0, 1'b0, 16'h0000);
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);
    check("rd_rsp_write", 32'(rsp_write), 32'd0);
    check("rd_mreq_low", 32'(abus_mreq), 32'd0);
    tick();
    check("rd_rsp_consumed", 32'(rsp_valid), 32'd0);

    // Foreign ack on a write
    set_cmd(1'b1, 16'h1234, 16'hA5A5);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("fa_mreq", 32'(abus_mreq), 32'd1);
    check("fa_mwrite", 32'(abus_mwrite), 32'd1);
    check("fa_wdata", 32'(abus_mwdata), 32'hA5A5);
    bus(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fa_no_complete", 32'(rsp_valid), 32'd0);
      check("fa_mreq_held", 32'(abus_mreq), 32'd1);
    end
    bus(1'b1, 1'b1, 16'hFFFF);
    tick();
    bus(1'b0, 1'b0, 16'h0000);
    check("fa_rsp_valid", 32'(rsp_valid), 32'd1);
    check("fa_rsp_rdata_zero", 32'(rsp_rdata), 32'd0);
    check("fa_rsp_write", 32'(rsp_write), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fa_single_rsp", 32'(rsp_valid), 32'd0);
      check("fa_idle", 32'(abus_mreq), 32'd0);
    end

    // FIFO full, never granted until later
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b0, 16'h0100 + 16'(i), 16'h0000);
      check("ff_ready_before", 32'(cmd_ready), 32'd1);
      tick();
    end
    set_cmd(1'b0, 16'h0104, 16'h0000);
    check("ff_full", 32'(cmd_ready), 32'd0);
    check("ff_head_addr", 32'(abus_maddress), 32'h0100);
    tick();
    tick();
    check("ff_still_full", 32'(cmd_ready), 32'd0);
    bus(1'b1, 1'b1, 16'h7777);
    tick();
    bus(1'b0, 1'b0, 16'h0000);
    check("ff_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ff_rsp_rdata", 32'(rsp_rdata), 32'h7777);
    check("ff_ready_after_pop", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("ff_full_again", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("ff_drain_mreq", 32'(abus_mreq), 32'd1);
      check("ff_drain_addr", 32'(abus_maddress), 32'h0101 + 32'(k));
      bus(1'b1, 1'b1, 16'h0100 + 16'(k));
      tick();
      bus(1'b0, 1'b0, 16'h0000);
      check("ff_drain_rsp", 32'(rsp_valid), 32'd1);
      check("ff_drain_rdata", 32'(rsp_rdata), 32'h0100 + 32'(k));
      tick();
    end
    check("ff_empty_idle", 32'(abus_mreq), 32'd0);

    // Response backpressure
    rsp_ready = 1'b0;
    set_cmd(1'b1, 16'h0200, 16'h5A5A);
    tick();
    set_cmd(1'b0, 16'h0201, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    check("bp_mreq", 32'(abus_mreq), 32'd1);
    check("bp_addr", 32'(abus_maddress), 32'h0200);
    bus(1'b1, 1'b1, 16'hDEAD);
    tick();
    bus(1'b0, 1'b0, 16'h0000);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rsp_rdata_zero", 32'(rsp_rdata), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_mreq_low", 32'(abus_mreq), 32'd0);
      check("bp_rsp_held", 32'(rsp_valid), 32'd1);
      check("bp_rsp_write_held", 32'(rsp_write), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("bp_next_mreq", 32'(abus_mreq), 32'd1);
    check("bp_next_addr", 32'(abus_maddress), 32'h0201);
    check("bp_next_mread", 32'(abus_mread), 32'd1);
    bus(1'b1, 1'b1, 16'h1357);
    tick();
    bus(1'b0, 1'b0, 16'h0000);
    check("bp_next_rdata", 32'(rsp_rdata), 32'h1357);
    tick();

    // Timeout and abort
    set_cmd(1'b0, 16'h0300, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("to_mreq", 32'(abus_mreq), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_no_abort_yet", 32'(abus_mabort), 32'd0);
    end
    tick();
    check("to_mabort", 32'(abus_mabort), 32'd1);
    check("to_mreq_kept", 32'(abus_mreq), 32'd1);
    check("to_addr_kept", 32'(abus_maddress), 32'h0300);
    tick();
    check("to_abort_held", 32'(abus_mabort), 32'd1);
    bus(1'b1, 1'b0, 16'hCAFE);
    tick();
    bus(1'b0, 1'b0, 16'h0000);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("to_mabort_clr", 32'(abus_mabort), 32'd0);
    check("to_mreq_clr", 32'(abus_mreq), 32'd0);
    tick();
    tick();
    check("to_fifo_popped", 32'(abus_mreq), 32'd0);

    // Asynchronous reset mid-transaction
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b0, 16'h0400 + 16'(i), 16'h0000);
      tick();
    end
    cmd_valid = 1'b0;
    check("ar_mreq_before", 32'(abus_mreq), 32'd1);
    #2 abus_rstb = 1'b0;
    #1;
    check("ar_mreq", 32'(abus_mreq), 32'd0);
    check("ar_addr", 32'(abus_maddress), 32'd0);
    check("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    check("ar_mid", 32'(abus_mid), 32'd5);
    tick();
    abus_rstb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_no_rsp", 32'(rsp_valid), 32'd0);
      check("ar_no_mreq", 32'(abus_mreq), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
